// File: rtl/chien_search_ctrl.sv
// Chien search sequencing controller for the RS(255,239) decoder.
// Accepts the locator degree from Berlekamp-Massey, drives the datapath
// load/scan strobes, realigns the delayed root flag with a symbol index,
// counts roots and reports the per-frame error count and failure flag.
module chien_search_ctrl #(
    parameter int N    = 255,
    parameter int T    = 8,
    parameter int LAT  = 13,
    parameter int ERRW = 4
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            bm_valid,
    output logic            bm_ready,
    input  logic [ERRW-1:0] lambda_deg,
    input  logic            frame_abort,
    output logic            chien_load,
    output logic            chien_en,
    input  logic            root_flag,
    output logic            pos_valid,
    output logic [7:0]      pos_idx,
    output logic            pos_err,
    output logic            frame_done,
    output logic [ERRW-1:0] err_cnt,
    output logic            decode_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DRAIN,
        S_REPORT
    } state_t;

    // One phase counter covers both the N-cycle scan and the LAT-cycle drain.
    localparam int CW = $clog2(((N > LAT) ? N : LAT) + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [ERRW-1:0] deg_q, deg_d;

    logic [ERRW-1:0] cnt_q, cnt_d;
    logic [7:0]      pos_q, pos_d;
    logic [LAT-1:0]  dly_q, dly_d;
    logic [ERRW-1:0] err_q, err_d;
    logic            fail_q, fail_d;
    logic            ready_q, ready_d;
    logic            load_q, load_d;
    logic            en_q, en_d;
    logic            done_q, done_d;

    logic            abort;
    logic            hit;

    // Root counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        if (&v) begin
            return v;
        end
        return v + ERRW'(1);
    endfunction

    // A frame is uncorrectable when the roots found disagree with the locator
    // degree, or when the degree itself is beyond the correction capability.
    function automatic logic judge_fail(input logic [ERRW-1:0] cnt,
                                        input logic [ERRW-1:0] deg);
        return (cnt != deg) || (int'(deg) > T);
    endfunction

    // Abort only has meaning while a frame is in flight.
    assign abort = frame_abort && (state_q != S_IDLE);
    assign hit   = pos_valid && root_flag;

    // Control state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            deg_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            deg_q   <= deg_d;
        end
    end

    // Next-state logic: handshake, fixed-length scan and drain phases, abort.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        deg_d   = deg_q;
        case (state_q)
            S_IDLE: begin
                if (bm_valid && ready_q) begin
                    state_d = S_LOAD;
                    deg_d   = lambda_deg;
                end
            end
            S_LOAD: begin
                state_d = S_SCAN;
                cyc_d   = '0;
            end
            S_SCAN: begin
                if (cyc_q == CW'(N - 1)) begin
                    state_d = S_DRAIN;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cyc_q == CW'(LAT - 1)) begin
                    state_d = S_REPORT;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Output logic: strobes decoded from the upcoming state so they appear
    // registered, plus the realignment delay line, counters and frame result.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        load_d  = (state_d == S_LOAD);
        en_d    = (state_d == S_SCAN);
        done_d  = (state_d == S_REPORT);

        // The delay line mirrors the datapath latency; flushing it on abort
        // keeps stale root flags from leaking into the next frame.
        if (abort) begin
            dly_d = '0;
        end else begin
            dly_d = {dly_q[LAT-2:0], en_q};
        end

        cnt_d = cnt_q;
        pos_d = pos_q;
        if (state_q == S_LOAD) begin
            cnt_d = '0;
            pos_d = 8'(N - 1);
        end else if (pos_valid) begin
            if (hit) begin
                cnt_d = sat_inc(cnt_q);
            end
            // Hold at zero after the last position rather than wrapping.
            if (pos_q != 8'd0) begin
                pos_d = pos_q - 8'd1;
            end
        end

        // The final root flag arrives in the last drain cycle, so the result
        // is taken from the counter's next value as the report begins.
        err_d  = err_q;
        fail_d = fail_q;
        if ((state_q == S_DRAIN) && (state_d == S_REPORT)) begin
            err_d  = cnt_d;
            fail_d = judge_fail(cnt_d, deg_q);
        end
    end

    // Output, counter and delay-line registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ready_q <= 1'b0;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            dly_q   <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            err_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            load_q  <= load_d;
            en_q    <= en_d;
            done_q  <= done_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign bm_ready    = ready_q;
    assign chien_load  = load_q;
    assign chien_en    = en_q;
    assign pos_valid   = dly_q[LAT-1];
    assign pos_idx     = pos_q;
    assign pos_err     = hit;
    assign frame_done  = done_q;
    assign err_cnt     = err_q;
    assign decode_fail = fail_q;

endmodule

// File: tb/tb_chien_search_ctrl.sv
// Self-checking bench for chien_search_ctrl: directed frames plus randomized
// root patterns, compared against a frame-level timing and result model.
`timescale 1ns/1ps
module tb_chien_search_ctrl;

    localparam int N    = 255;
    localparam int T    = 8;
    localparam int LAT  = 13;
    localparam int ERRW = 4;
    localparam int SAT  = (1 << ERRW) - 1;

    logic            sys_clk     = 1'b0;
    logic            sys_rst_n   = 1'b0;
    logic            bm_valid    = 1'b0;
    logic [ERRW-1:0] lambda_deg  = '0;
    logic            frame_abort = 1'b0;
    logic            root_flag   = 1'b0;
    logic            bm_ready;
    logic            chien_load;
    logic            chien_en;
    logic            pos_valid;
    logic [7:0]      pos_idx;
    logic            pos_err;
    logic            frame_done;
    logic [ERRW-1:0] err_cnt;
    logic            decode_fail;

    chien_search_ctrl #(.N(N), .T(T), .LAT(LAT), .ERRW(ERRW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .bm_valid   (bm_valid),
        .bm_ready   (bm_ready),
        .lambda_deg (lambda_deg),
        .frame_abort(frame_abort),
        .chien_load (chien_load),
        .chien_en   (chien_en),
        .root_flag  (root_flag),
        .pos_valid  (pos_valid),
        .pos_idx    (pos_idx),
        .pos_err    (pos_err),
        .frame_done (frame_done),
        .err_cnt    (err_cnt),
        .decode_fail(decode_fail)
    );

    always #5 sys_clk = ~sys_clk;

    int n_total = 0;
    int n_pass  = 0;
    bit root_at [0:N-1];
    int prev_cnt  = 0;
    int prev_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".bm_ready"}, bm_ready, 0);
        chk({tag, ".chien_load"}, chien_load, 0);
        chk({tag, ".chien_en"}, chien_en, 0);
        chk({tag, ".pos_valid"}, pos_valid, 0);
        chk({tag, ".pos_idx"}, pos_idx, 0);
        chk({tag, ".pos_err"}, pos_err, 0);
        chk({tag, ".frame_done"}, frame_done, 0);
        chk({tag, ".err_cnt"}, err_cnt, 0);
        chk({tag, ".decode_fail"}, decode_fail, 0);
    endtask

    // Edge, then 1ns later: the drive point of the new cycle.
    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_roots();
        for (int i = 0; i < N; i++) root_at[i] = 1'b0;
    endtask

    // Frame result from the root table: count the roots, saturate, compare.
    task automatic model(input int deg, output int ecnt, output int efail);
        int n;
        n = 0;
        for (int i = 0; i < N; i++) if (root_at[i]) n++;
        ecnt  = (n > SAT) ? SAT : n;
        efail = ((ecnt != deg) || (deg > T)) ? 1 : 0;
    endtask

    // One frame, entered and left at a check point (drive point + 1ns).
    // abort_k / rst_k: cycle offset from the handshake at which to abort or
    // reset (-1 = never). k counts cycles after the handshake cycle.
    task automatic run_frame(input int deg, input int abort_k, input int rst_k,
                             input bit noise, input bit hold_valid,
                             input bit abort_at_hs, input bit expect_immediate);
        int waits;
        int ecnt, efail;
        int j;
        bit valid;
        waits = 0;
        model(deg, ecnt, efail);
        lambda_deg  = 4'(deg);
        bm_valid    = 1'b1;
        frame_abort = abort_at_hs;
        while (!bm_ready && waits < 20) begin
            next_cycle();
            #1;
            waits++;
        end
        if (!bm_ready) begin
            chk("handshake_timeout", 0, 1);
            bm_valid    = 1'b0;
            frame_abort = 1'b0;
            return;
        end
        if (expect_immediate) chk("handshake_latency", waits, 0);

        for (int k = 1; k <= N + 3 + LAT; k++) begin
            next_cycle();
            if (!hold_valid) bm_valid = 1'b0;
            frame_abort = (k == abort_k);
            j     = k - 2 - LAT;
            valid = (k >= 2 + LAT) && (k <= N + 1 + LAT) && (abort_k < 0 || k <= abort_k);
            if (valid) root_flag = root_at[N-1-j];
            else       root_flag = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;

            if (abort_k >= 0 && k > abort_k) begin
                chk("abort.chien_en", chien_en, 0);
                chk("abort.chien_load", chien_load, 0);
                chk("abort.pos_valid", pos_valid, 0);
                chk("abort.pos_err", pos_err, 0);
                chk("abort.frame_done", frame_done, 0);
                chk("abort.bm_ready", bm_ready, 1);
                chk("abort.err_cnt", err_cnt, prev_cnt);
                chk("abort.decode_fail", decode_fail, prev_fail);
                bm_valid    = 1'b0;
                frame_abort = 1'b0;
                root_flag   = 1'b0;
                // Idle for a while: no late report must appear.
                for (int i = 0; i < N + LAT; i++) begin
                    next_cycle();
                    #1;
                    chk("abort.no_done", frame_done, 0);
                end
                chk("abort.err_hold", err_cnt, prev_cnt);
                chk("abort.fail_hold", decode_fail, prev_fail);
                return;
            end

            if (k == rst_k) begin
                sys_rst_n = 1'b0;
                bm_valid  = 1'b0;
                root_flag = 1'b0;
                #1;
                chk_zero("rst_mid");
                for (int i = 0; i < 2; i++) begin
                    next_cycle();
                    #1;
                    chk_zero("rst_hold");
                end
                sys_rst_n = 1'b1;
                next_cycle();
                #1;
                chk("rst_release.bm_ready", bm_ready, 1);
                chk("rst_release.chien_en", chien_en, 0);
                prev_cnt  = 0;
                prev_fail = 0;
                return;
            end

            chk("chien_load", chien_load, (k == 1));
            chk("chien_en", chien_en, (k >= 2 && k <= N + 1));
            chk("pos_valid", pos_valid, valid);
            if (valid) chk("pos_idx", pos_idx, N - 1 - j);
            chk("pos_err", pos_err, (valid && root_flag));
            chk("frame_done", frame_done, (k == N + 2 + LAT));
            chk("bm_ready", bm_ready, (k == N + 3 + LAT));
            chk("err_cnt", err_cnt, (k >= N + 2 + LAT) ? ecnt : prev_cnt);
            chk("decode_fail", decode_fail, (k >= N + 2 + LAT) ? efail : prev_fail);
        end
        prev_cnt    = ecnt;
        prev_fail   = efail;
        frame_abort = 1'b0;
        root_flag   = 1'b0;
        if (!hold_valid) bm_valid = 1'b0;
    endtask

    initial begin
        int rdeg;
        int nroots;

        // Reset: all outputs low while asserted, bm_ready one clock after release.
        #12;
        chk_zero("reset");
        #15;
        sys_rst_n = 1'b1;
        chk("reset.ready_before_clk", bm_ready, 0);
        next_cycle();
        #1;
        chk("reset.ready_after_clk", bm_ready, 1);

        // Degree 0, no roots; abort raised together with the handshake in IDLE.
        clear_roots();
        run_frame(0, -1, -1, 1'b0, 1'b0, 1'b1, 1'b1);

        // frame_abort in IDLE is ignored.
        frame_abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            chk("idle_abort.bm_ready", bm_ready, 1);
            chk("idle_abort.err_cnt", err_cnt, prev_cnt);
        end
        frame_abort = 1'b0;

        // Three roots at 200, 17, 0 against degree 3.
        clear_roots();
        root_at[200] = 1'b1;
        root_at[17]  = 1'b1;
        root_at[0]   = 1'b1;
        run_frame(3, -1, -1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Too few roots, then degree beyond T with matching count.
        clear_roots();
        root_at[254] = 1'b1;
        root_at[100] = 1'b1;
        run_frame(4, -1, -1, 1'b1, 1'b0, 1'b0, 1'b1);
        clear_roots();
        for (int i = 0; i < 9; i++) root_at[i * 27 + 3] = 1'b1;
        run_frame(9, -1, -1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Root flag held high across the scan: count saturates.
        for (int i = 0; i < N; i++) root_at[i] = 1'b1;
        run_frame(8, -1, -1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Degree 0 with a single root is a failure.
        clear_roots();
        root_at[128] = 1'b1;
        run_frame(0, -1, -1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Abort in scan cycle 100 (scan cycle 0 is k=2).
        clear_roots();
        root_at[250] = 1'b1;
        root_at[160] = 1'b1;
        run_frame(2, 102, -1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Randomized degrees and root patterns.
        for (int f = 0; f < 4; f++) begin
            clear_roots();
            rdeg   = $urandom_range(0, 10);
            nroots = $urandom_range(0, 12);
            for (int r = 0; r < nroots; r++) root_at[$urandom_range(0, N - 1)] = 1'b1;
            run_frame(rdeg, -1, -1, 1'b1, 1'b0, 1'b0, 1'b1);
        end

        // Async reset in scan cycle 50, then back-to-back frames, valid held.
        clear_roots();
        root_at[240] = 1'b1;
        run_frame(3, -1, 52, 1'b1, 1'b1, 1'b0, 1'b1);
        clear_roots();
        root_at[77] = 1'b1;
        root_at[5]  = 1'b1;
        run_frame(2, -1, -1, 1'b1, 1'b1, 1'b0, 1'b1);
        clear_roots();
        root_at[199] = 1'b1;
        run_frame(5, -1, -1, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
